// File: rtl/redmule_mx_pkg.sv
// Shared definitions for the MX (MXFP8) conversion blocks.
//   - exponent biases of the FP16, FP8 E4M3 and E8M0 formats
//   - combined rebias offset used when expanding E4M3 + E8M0 to FP16
//   - FP16 special-value magnitudes (sign bit is prepended by the user)
//   - decoder FSM state encoding
package redmule_mx_pkg;

  localparam int unsigned FP16_BIAS = 15;
  localparam int unsigned FP8_BIAS  = 7;
  localparam int unsigned E8M0_BIAS = 127;

  // FP16 exponent = e8 + X - (FP8_BIAS + E8M0_BIAS - FP16_BIAS) = e8 + X - 119
  localparam int unsigned MX_EXP_OFFSET = FP8_BIAS + E8M0_BIAS - FP16_BIAS;

  // 15-bit magnitudes {exp[4:0], man[9:0]}
  localparam logic [14:0] FP16_NAN_MAG     = {5'h1F, 10'h200};
  localparam logic [14:0] FP16_INF_MAG     = {5'h1F, 10'h000};
  localparam logic [14:0] FP16_MAX_MAG     = {5'h1E, 10'h3FF};
  localparam logic [14:0] FP16_ZERO_MAG    = 15'h0000;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } dec_state_e;

endpackage

// File: rtl/redmule_mx_fp8_to_fp16.sv
// Combinational converter: one E4M3 element scaled by an E8M0 shared
// exponent, producing one FP16 value. Subnormal inputs and results flush
// to signed zero; overflow saturates to the largest finite FP16 value.
// Ports:
//   elem_i        E4M3 element {s, e[3:0], m[2:0]}
//   shared_exp_i  E8M0 shared exponent (8'hFF encodes NaN)
//   fp16_o        FP16 result
module redmule_mx_fp8_to_fp16
  import redmule_mx_pkg::*;
(
  input  logic [7:0]  elem_i,
  input  logic [7:0]  shared_exp_i,
  output logic [15:0] fp16_o
);

  logic       sgn;
  logic [3:0] e8;
  logic [2:0] m8;
  logic [9:0] e16;

  assign sgn = elem_i[7];
  assign e8  = elem_i[6:3];
  assign m8  = elem_i[2:0];

  // 10 bits holds the full range -118..149 as two's complement
  assign e16 = {6'b0, e8} + {2'b0, shared_exp_i} - 10'(MX_EXP_OFFSET);

  always_comb begin
    fp16_o = {sgn, FP16_ZERO_MAG};
    if (shared_exp_i == 8'hFF) begin
      fp16_o = {sgn, FP16_NAN_MAG};
    end else if (e8 == 4'h0) begin
      fp16_o = {sgn, FP16_ZERO_MAG};
    end else if (e8 == 4'hF) begin
      fp16_o = (m8 == 3'b0) ? {sgn, FP16_INF_MAG} : {sgn, FP16_NAN_MAG};
    end else if ($signed(e16) <= 10'sd0) begin
      fp16_o = {sgn, FP16_ZERO_MAG};
    end else if ($signed(e16) >= 10'sd31) begin
      fp16_o = {sgn, FP16_MAX_MAG};
    end else begin
      fp16_o = {sgn, e16[4:0], m8, 7'b0};
    end
  end

endmodule

// File: rtl/redmule_mx_decoder.sv
// MXFP8 block decoder: accepts one block of E4M3 elements together with its
// E8M0 shared exponent and replays it as NUM_GROUPS beats of NUM_LANES FP16
// values. Block and exponent are only taken together; no new block is taken
// while a block is being emitted.
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   mx_val_valid_i/ready_o/data_i     element block, element i at [8i +: 8]
//   mx_exp_valid_i/ready_o/data_i     E8M0 shared exponent
//   fp16_valid_o/ready_i/data_o       FP16 beat, lane l at [BITW*l +: BITW]
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for element block and shared exponent to be valid together
// EMIT  | presenting group group_idx_q; advances on each downstream accept
module redmule_mx_decoder
  import redmule_mx_pkg::*;
#(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned BITW      = 16,
  parameter int unsigned NUM_LANES = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      mx_val_valid_i,
  output logic                      mx_val_ready_o,
  input  logic [DATA_W-1:0]         mx_val_data_i,
  input  logic                      mx_exp_valid_i,
  output logic                      mx_exp_ready_o,
  input  logic [7:0]                mx_exp_data_i,
  output logic                      fp16_valid_o,
  input  logic                      fp16_ready_i,
  output logic [NUM_LANES*BITW-1:0] fp16_data_o
);

  localparam int unsigned NUM_ELEMS  = DATA_W / 8;
  localparam int unsigned NUM_GROUPS = NUM_ELEMS / NUM_LANES;
  localparam int unsigned GIDX_W     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int unsigned GRP_W      = NUM_LANES * 8;

  dec_state_e          state_q, state_d;
  logic [GIDX_W-1:0]   group_idx_q, group_idx_d;
  logic [DATA_W-1:0]   val_buf_q, val_buf_d;
  logic [7:0]          exp_q, exp_d;

  logic                accept;
  logic                last_group;
  logic [GRP_W-1:0]    grp_elems;

  assign accept     = (state_q == IDLE) && mx_val_valid_i && mx_exp_valid_i;
  assign last_group = (group_idx_q == GIDX_W'(NUM_GROUPS - 1));

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      group_idx_q <= '0;
      val_buf_q   <= '0;
      exp_q       <= '0;
    end else begin
      state_q     <= state_d;
      group_idx_q <= group_idx_d;
      val_buf_q   <= val_buf_d;
      exp_q       <= exp_d;
    end
  end

  // next-state
  always_comb begin
    state_d     = state_q;
    group_idx_d = group_idx_q;
    val_buf_d   = val_buf_q;
    exp_d       = exp_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          val_buf_d   = mx_val_data_i;
          exp_d       = mx_exp_data_i;
          group_idx_d = '0;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (fp16_ready_i) begin
          if (last_group) begin
            group_idx_d = '0;
            state_d     = IDLE;
          end else begin
            group_idx_d = group_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    mx_val_ready_o = accept;
    mx_exp_ready_o = accept;
    fp16_valid_o   = (state_q == EMIT);
  end

  // Data comes only from registered state, so it holds while stalled.
  always_comb begin
    grp_elems = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (group_idx_q == GIDX_W'(g)) grp_elems = val_buf_q[g*GRP_W +: GRP_W];
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    redmule_mx_fp8_to_fp16 i_cvt (
      .elem_i      (grp_elems[8*l +: 8]),
      .shared_exp_i(exp_q),
      .fp16_o      (fp16_data_o[BITW*l +: BITW])
    );
  end

endmodule
